// File: rtl/btn_pkg.sv
// btn_pkg: shared constants for the push-button conditioner
package btn_pkg;
  localparam int SAMPLE_DIV_DEF   = 50000;
  localparam int DB_SAMPLES_DEF   = 4;
  localparam int LONG_TICKS_DEF   = 256;
  localparam int REPEAT_TICKS_DEF = 64;
  localparam int SAMPLE_DIV_TB    = 4;
  localparam int DB_SAMPLES_TB    = 3;
  localparam int LONG_TICKS_TB    = 5;
  localparam int REPEAT_TICKS_TB  = 2;
endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: one-cycle tick every SAMPLE_DIV clocks, shareable between buttons
module sample_tick_gen import btn_pkg::*; #(
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = $clog2(SAMPLE_DIV);
  logic [CW-1:0] cnt_q;
  assign tick = cnt_q == CW'(SAMPLE_DIV - 1);
  // free-running prescaler wrapping at SAMPLE_DIV-1
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else     cnt_q <= tick ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: sync, debounce, edge pulses, long press and auto-repeat for one button
module button_conditioner import btn_pkg::*; #(
  parameter int SAMPLE_DIV   = SAMPLE_DIV_DEF,
  parameter int DB_SAMPLES   = DB_SAMPLES_DEF,
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic long_held
);
  localparam int HW = $clog2(LONG_TICKS + REPEAT_TICKS) + 1;
  localparam logic [HW-1:0] LV  = HW'(LONG_TICKS);
  localparam logic [HW-1:0] LRV = HW'(LONG_TICKS + REPEAT_TICKS);
  logic s1_q, s2_q, tick, tick_d_q;
  logic level_q, press_q, release_q, long_q, held_q;
  logic [DB_SAMPLES-1:0] sh_q;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic level_d, adv, long_ev, rep_ev, held_d;
  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );
  // level only moves on a unanimous window; hold counter advances on ticks while pressed
  always_comb begin
    level_d  = tick_d_q ? (&sh_q ? 1'b1 : ~|sh_q ? 1'b0 : level_q) : level_q;
    adv      = tick & level_q & level_d;
    hold_inc = hold_q + 1'b1;
    long_ev  = adv & ~held_q & (hold_inc == LV);
    rep_ev   = adv & held_q & repeat_en & (hold_inc == LRV);
    hold_d   = ~level_d ? '0 :
               ~adv ? hold_q :
               rep_ev ? LV :
               (held_q & ~repeat_en & (hold_q >= LV)) ? hold_q : hold_inc;
    held_d   = level_d & (held_q | long_ev);
  end
  // synchroniser, sample shift register and registered outputs
  always_ff @(posedge clk)
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      tick_d_q  <= 1'b0;
      sh_q      <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      tick_d_q  <= tick;
      sh_q      <= tick ? {sh_q[DB_SAMPLES-2:0], s2_q} : sh_q;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= (level_d & ~level_q) | rep_ev;
      release_q <= ~level_d & level_q;
      long_q    <= long_ev;
      held_q    <= held_d;
    end
  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign long_held     = held_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench with hand-computed pulse sequences and spacings
module tb_button_conditioner;
  import btn_pkg::*;
  logic clk = 1'b0, rst = 1'b1, btn_raw = 1'b0, repeat_en = 1'b0;
  logic level, press_pulse, release_pulse, long_pulse, long_held;
  typedef struct {logic [2:0] code; int gap;} exp_t;
  localparam logic [2:0] P = 3'b100, R = 3'b010, L = 3'b001;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0, cyc = 0, last_cyc = 0;

  button_conditioner #(
    .SAMPLE_DIV  (SAMPLE_DIV_TB),
    .DB_SAMPLES  (DB_SAMPLES_TB),
    .LONG_TICKS  (LONG_TICKS_TB),
    .REPEAT_TICKS(REPEAT_TICKS_TB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .repeat_en    (repeat_en),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .long_held    (long_held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] c, input int g);
    q.push_back('{code: c, gap: g});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_level(input logic v, output int n);
    n = 0;
    while (level !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait for level", int'(level), int'(v));
  endtask

  // monitor: every pulse pops the next expected event; gap 0 means spacing not checked
  always @(negedge clk) begin
    cyc++;
    if (press_pulse | release_pulse | long_pulse) begin
      if (q.size() == 0) chk("unexpected pulse", int'({press_pulse, release_pulse, long_pulse}), 0);
      else begin
        e = q.pop_front();
        chk("pulse kind", int'({press_pulse, release_pulse, long_pulse}), int'(e.code));
        if (e.gap != 0) chk("pulse gap", cyc - last_cyc, e.gap);
        if (press_pulse) chk("level at press", int'(level), 1);
        if (release_pulse) chk("level at release", int'(level), 0);
      end
      last_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    idle(2);
    chk("reset level", int'(level), 0);
    chk("reset press", int'(press_pulse), 0);
    chk("reset release", int'(release_pulse), 0);
    chk("reset long", int'(long_pulse), 0);
    chk("reset held", int'(long_held), 0);
    rst = 1'b0;
    idle(10);
    // clean short press: 3 samples high, level high for 3 ticks
    push(P, 0); push(R, 12);
    btn_raw = 1'b1; idle(12); btn_raw = 1'b0; idle(40);
    // glitch under two ticks
    seen = 0;
    btn_raw = 1'b1; idle(5); btn_raw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= int'(level);
    end
    chk("glitch level", seen, 0);
    // long press without repeat
    repeat_en = 1'b0;
    push(P, 0); push(L, 19); push(R, 61);
    btn_raw = 1'b1; idle(80);
    chk("held before release", int'(long_held), 1);
    btn_raw = 1'b0; idle(40);
    chk("held after release", int'(long_held), 0);
    // auto-repeat, repeat_en dropped after the tick-9 repeat
    repeat_en = 1'b1;
    push(P, 0); push(L, 19); push(P, 8); push(P, 8); push(R, 65);
    btn_raw = 1'b1;
    wait_level(1'b1, n);
    idle(38);
    repeat_en = 1'b0;
    idle(100 - n - 38);
    btn_raw = 1'b0; idle(40);
    // release before the next repeat fires
    repeat_en = 1'b1;
    push(P, 0); push(L, 19); push(P, 8); push(R, 5);
    btn_raw = 1'b1; idle(32); btn_raw = 1'b0;
    wait_level(1'b0, n);
    idle(1);
    chk("held after release in repeat", int'(long_held), 0);
    chk("hold_cnt after release", int'(dut.hold_q), 0);
    idle(40);
    // reset during a long hold
    repeat_en = 1'b0;
    push(P, 0); push(L, 19);
    btn_raw = 1'b1;
    n = 0;
    while (long_held !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait for long_held", int'(long_held), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midhold rst level", int'(level), 0);
    chk("midhold rst press", int'(press_pulse), 0);
    chk("midhold rst release", int'(release_pulse), 0);
    chk("midhold rst long", int'(long_pulse), 0);
    chk("midhold rst held", int'(long_held), 0);
    push(P, 0); push(R, 0);
    @(negedge clk);
    rst = 1'b0;
    idle(14);
    btn_raw = 1'b0;
    idle(60);
    chk("scoreboard drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
